// File: rtl/uart_vector_parser_pkg.sv
// Shared types for the UART vector-point deframer and its output slot.
package vector_pkg;

  localparam int         PT_XY_W        = 12;
  localparam int         PT_RGB_W       = 8;
  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_B1    = 3'd1,
    S_B2    = 3'd2,
    S_B3    = 3'd3,
    S_B4    = 3'd4,
    S_CKSUM = 3'd5
  } state_e;

  typedef struct packed {
    logic [PT_XY_W-1:0]  x;
    logic [PT_XY_W-1:0]  y;
    logic [PT_RGB_W-1:0] rgb;
  } point_t;

endpackage

// File: rtl/uart_vector_parser_if.sv
// Valid/ready point bus between the deframer slot and the point FIFO / drawing engine.
interface uart_vector_parser_if;
  import vector_pkg::*;

  logic   valid;
  logic   ready;
  point_t pt;

  modport master (output valid, output pt, input ready);
  modport slave  (input valid, input pt, output ready);

endinterface

// File: rtl/uart_vector_parser_slot.sv
// vec_point_slot: one-entry valid/ready output register; a completion that finds
// the slot occupied and not draining is dropped and flagged as overrun.
module vec_point_slot
  import vector_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  point_t pt_i,
  output logic   overrun_o,
  uart_vector_parser_if.master out_if
);

  logic   valid_q, valid_d;
  point_t pt_q, pt_d;
  logic   ovr_q, ovr_d;

  always_comb begin
    valid_d = valid_q;
    pt_d    = pt_q;
    ovr_d   = 1'b0;
    if (load_i) begin
      if (!valid_q || out_if.ready) begin
        valid_d = 1'b1;
        pt_d    = pt_i;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (out_if.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pt_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pt_q    <= pt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.pt    = pt_q;
  assign overrun_o    = ovr_q;

endmodule

// File: rtl/uart_vector_parser.sv
// UART byte-stream deframer producing X/Y/RGB vector points.
// UART_VECTOR_PARSER_CHECKSUM_EN adds the trailing XOR checksum byte and its check.
module uart_vector_parser
  import vector_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DFLT,
  parameter int         TIMEOUT_CLKS = 8720
) (
  input  logic                i_Clock,
  input  logic                i_Rst_n,
  input  logic                i_Rx_DV,
  input  logic [7:0]          i_Rx_Byte,
  output logic                o_Pt_Valid,
  input  logic                i_Pt_Ready,
  output logic [PT_XY_W-1:0]  o_Pt_X,
  output logic [PT_XY_W-1:0]  o_Pt_Y,
  output logic [PT_RGB_W-1:0] o_Pt_Rgb,
  output logic                o_Err_Cksum,
  output logic                o_Err_Overrun,
  output logic                o_Err_Timeout
);

  localparam int             CNT_W   = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       xlo_q, xlo_d;
  logic [7:0]       ylo_q, ylo_d;
  logic             complete;
  logic             timeout;
  logic             err_to_q;
  point_t           pt_new;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
  logic [7:0]       rgb_q, rgb_d;
  logic [7:0]       xor_q, xor_d;
  logic             ck_bad;
  logic             err_ck_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    xlo_d    = xlo_q;
    ylo_d    = ylo_q;
    complete = 1'b0;
    timeout  = 1'b0;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
    rgb_d    = rgb_q;
    xor_d    = xor_q;
    ck_bad   = 1'b0;
`endif
    if (i_Rx_DV)
      cnt_d = '0;
    else if (state_q != S_HUNT && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;

    // A byte arriving on the deadline cycle is still processed.
    if (i_Rx_DV) begin
      case (state_q)
        S_HUNT: if (i_Rx_Byte == SYNC_BYTE) begin
          state_d = S_B1;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
        S_B1: begin
          hi_d    = i_Rx_Byte;
          state_d = S_B2;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
          xor_d   = xor_q ^ i_Rx_Byte;
`endif
        end
        S_B2: begin
          xlo_d   = i_Rx_Byte;
          state_d = S_B3;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
          xor_d   = xor_q ^ i_Rx_Byte;
`endif
        end
        S_B3: begin
          ylo_d   = i_Rx_Byte;
          state_d = S_B4;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
          xor_d   = xor_q ^ i_Rx_Byte;
`endif
        end
        S_B4: begin
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
          rgb_d    = i_Rx_Byte;
          xor_d    = xor_q ^ i_Rx_Byte;
          state_d  = S_CKSUM;
`else
          complete = 1'b1;
          state_d  = S_HUNT;
`endif
        end
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
        S_CKSUM: begin
          if (xor_q == i_Rx_Byte) complete = 1'b1;
          else                    ck_bad   = 1'b1;
          state_d = S_HUNT;
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end else if (state_q != S_HUNT && cnt_q == TO_LAST) begin
      timeout = 1'b1;
      state_d = S_HUNT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_HUNT;
      cnt_q    <= '0;
      hi_q     <= '0;
      xlo_q    <= '0;
      ylo_q    <= '0;
      err_to_q <= 1'b0;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
      rgb_q    <= '0;
      xor_q    <= '0;
      err_ck_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      xlo_q    <= xlo_d;
      ylo_q    <= ylo_d;
      err_to_q <= timeout;
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
      rgb_q    <= rgb_d;
      xor_q    <= xor_d;
      err_ck_q <= ck_bad;
`endif
    end
  end

  assign pt_new.x = {hi_q[7:4], xlo_q};
  assign pt_new.y = {hi_q[3:0], ylo_q};
`ifdef UART_VECTOR_PARSER_CHECKSUM_EN
  assign pt_new.rgb  = rgb_q;
  assign o_Err_Cksum = err_ck_q;
`else
  // Without a checksum the colour byte is the final byte, taken straight off the bus.
  assign pt_new.rgb  = i_Rx_Byte;
  assign o_Err_Cksum = 1'b0;
`endif

  uart_vector_parser_if pt_bus ();

  vec_point_slot u_slot (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .load_i    (complete),
    .pt_i      (pt_new),
    .overrun_o (o_Err_Overrun),
    .out_if    (pt_bus)
  );

  assign pt_bus.ready  = i_Pt_Ready;
  assign o_Pt_Valid    = pt_bus.valid;
  assign o_Pt_X        = pt_bus.pt.x;
  assign o_Pt_Y        = pt_bus.pt.y;
  assign o_Pt_Rgb      = pt_bus.pt.rgb;
  assign o_Err_Timeout = err_to_q;

endmodule
